// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch path: fetch state encoding,
// default widths and reset PC, and the instruction alignment rule.
package cpu_pkg;

    localparam int          ADDR_W_DEFAULT   = 64;
    localparam int          INSTR_W_DEFAULT  = 32;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

    // Low PC bits that must be zero for a 4-byte aligned instruction address.
    localparam logic [1:0]  ALIGN_MASK       = 2'b11;

    typedef enum logic [1:0] {
        FETCH_START = 2'd0,  // idle cycle after reset before the first request
        FETCH_REQ   = 2'd1,  // request outstanding to instruction memory
        FETCH_HOLD  = 2'd2,  // instruction held for decode
        FETCH_FAULT = 2'd3   // misaligned PC seen at retire; terminal until reset
    } fetch_state_e;

    function automatic logic pc_is_aligned(input logic [1:0] pc_low);
        return (pc_low & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the architectural PC, fetches one instruction
// per PC over a req/ack memory handshake, presents it to decode over
// valid/ready, and loads the next PC on retire. A misaligned next PC raises a
// sticky fault and stops fetching until reset.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter int                INSTR_W  = INSTR_W_DEFAULT
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [ADDR_W-1:0]  NextPC,
    output logic               IMemReq,
    output logic [ADDR_W-1:0]  IMemAddr,
    input  logic               IMemAck,
    input  logic [INSTR_W-1:0] IMemData,
    output logic [ADDR_W-1:0]  CurrentPC,
    output logic [INSTR_W-1:0] Instruction,
    output logic               InstrValid,
    input  logic               InstrReady,
    output logic               PCFault
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               fault_q, fault_d;

    // Next-state and register-update logic for the fetch FSM, PC and instruction.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        fault_d = fault_q;

        unique case (state_q)
            FETCH_START: state_d = FETCH_REQ;

            FETCH_REQ: begin
                if (IMemAck) begin
                    instr_d = IMemData;
                    state_d = FETCH_HOLD;
                end
            end

            // InstrValid is 1 throughout HOLD, so InstrReady alone means retire.
            FETCH_HOLD: begin
                if (InstrReady) begin
                    if (pc_is_aligned(NextPC[1:0])) begin
                        pc_d    = NextPC;
                        state_d = FETCH_REQ;
                    end else begin
                        fault_d = 1'b1;
                        state_d = FETCH_FAULT;
                    end
                end
            end

            FETCH_FAULT: state_d = FETCH_FAULT;

            default: state_d = FETCH_START;
        endcase
    end

    // State registers with synchronous reset taking priority over any ack or retire.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (Reset) begin
            state_q <= FETCH_START;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    // Outputs decoded from registered state only; no input reaches an output combinationally.
    always_comb begin
        IMemReq     = (state_q == FETCH_REQ);
        InstrValid  = (state_q == FETCH_HOLD);
        IMemAddr    = pc_q;
        CurrentPC   = pc_q;
        Instruction = instr_q;
        PCFault     = fault_q;
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit. Directed steps plus a
// randomized fetch/retire loop, checked against a transaction-level model
// (expected PC, held instruction, fault flag) kept in the bench.
module tb_instruction_fetch_unit;

    localparam int          ADDR_W   = 64;
    localparam int          INSTR_W  = 32;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic               CLK;
    logic               Reset;
    logic [ADDR_W-1:0]  NextPC;
    logic               IMemReq;
    logic [ADDR_W-1:0]  IMemAddr;
    logic               IMemAck;
    logic [INSTR_W-1:0] IMemData;
    logic [ADDR_W-1:0]  CurrentPC;
    logic [INSTR_W-1:0] Instruction;
    logic               InstrValid;
    logic               InstrReady;
    logic               PCFault;

    int checks = 0;
    int errors = 0;

    // Reference model: what the PC and held instruction must be.
    logic [ADDR_W-1:0]  exp_pc;
    logic [INSTR_W-1:0] exp_instr;

    instruction_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .INSTR_W  (INSTR_W)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .NextPC      (NextPC),
        .IMemReq     (IMemReq),
        .IMemAddr    (IMemAddr),
        .IMemAck     (IMemAck),
        .IMemData    (IMemData),
        .CurrentPC   (CurrentPC),
        .Instruction (Instruction),
        .InstrValid  (InstrValid),
        .InstrReady  (InstrReady),
        .PCFault     (PCFault)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One clock: inputs set at the negedge are taken at the posedge; outputs sampled at next negedge.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic check_requesting(input string tag);
        check({tag, ".req"},   IMemReq,    1'b1);
        check({tag, ".addr"},  IMemAddr,   exp_pc);
        check({tag, ".valid"}, InstrValid, 1'b0);
    endtask

    task automatic check_holding(input string tag);
        check({tag, ".valid"}, InstrValid,  1'b1);
        check({tag, ".req"},   IMemReq,     1'b0);
        check({tag, ".instr"}, Instruction, exp_instr);
        check({tag, ".pc"},    CurrentPC,   exp_pc);
        check({tag, ".fault"}, PCFault,     1'b0);
    endtask

    task automatic do_reset();
        Reset      = 1'b1;
        IMemAck    = 1'b0;
        InstrReady = 1'b0;
        step();
        exp_pc    = RESET_PC;
        exp_instr = '0;
        check("rst.req",   IMemReq,     1'b0);
        check("rst.valid", InstrValid,  1'b0);
        check("rst.pc",    CurrentPC,   RESET_PC);
        check("rst.instr", Instruction, '0);
        check("rst.fault", PCFault,     1'b0);
        Reset = 1'b0;
        step();
        check_requesting("first_req");
    endtask

    // From a requesting state: hold ack low for wait_states cycles, then ack with data.
    task automatic fetch(input int wait_states, input logic [INSTR_W-1:0] data);
        for (int i = 0; i < wait_states; i++) begin
            check_requesting("fetch.wait");
            IMemAck  = 1'b0;
            IMemData = $urandom;
            step();
        end
        check_requesting("fetch.ackcyc");
        IMemAck  = 1'b1;
        IMemData = data;
        step();
        IMemAck   = 1'b0;
        exp_instr = data;
        check_holding("fetch.hold");
    endtask

    // From a holding state: stall for stall cycles (optionally with stray acks), then retire.
    task automatic retire(input int stall, input logic [ADDR_W-1:0] next_pc, input logic stray_ack);
        for (int i = 0; i < stall; i++) begin
            InstrReady = 1'b0;
            IMemAck    = stray_ack;
            IMemData   = $urandom;
            NextPC     = {$urandom, $urandom};
            step();
            check_holding("stall");
        end
        IMemAck    = 1'b0;
        InstrReady = 1'b1;
        NextPC     = next_pc;
        step();
        InstrReady = 1'b0;
        if (next_pc[1:0] == 2'b00) begin
            exp_pc = next_pc;
            check_requesting("retire");
            check("retire.fault", PCFault, 1'b0);
        end else begin
            check("fault.flag",  PCFault,    1'b1);
            check("fault.pc",    CurrentPC,  exp_pc);
            check("fault.req",   IMemReq,    1'b0);
            check("fault.valid", InstrValid, 1'b0);
        end
    endtask

    initial begin
        Reset      = 1'b1;
        NextPC     = '0;
        IMemAck    = 1'b0;
        IMemData   = '0;
        InstrReady = 1'b0;

        // 1: zero-wait fetches, PC 0,4,8, one instruction every 2 cycles.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            check("seq.pc", CurrentPC, 64'(k * 4));
            fetch(0, 32'hF800_0000);
            retire(0, exp_pc + 64'd4, 1'b0);
        end

        // 2: ack delayed by 3 cycles; request held 4 cycles.
        fetch(3, 32'h1234_5678);

        // 3: stall 5 cycles, retire on the 6th with NextPC=0x40.
        retire(5, 64'h40, 1'b0);
        check("stall.addr40", IMemAddr, 64'h40);

        // 6: PC at the top of the space wraps to 0; stray acks in HOLD are ignored.
        fetch(1, 32'hCAFE_F00D);
        retire(0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        fetch(0, 32'h0BAD_BEEF);
        check("wrap.pc_top", CurrentPC, 64'hFFFF_FFFF_FFFF_FFFC);
        retire(4, 64'h0, 1'b1);
        check("wrap.pc_zero", CurrentPC, 64'h0);

        // Randomized fetch/retire traffic with aligned next PCs.
        for (int n = 0; n < 40; n++) begin
            logic [ADDR_W-1:0] npc;
            npc = ($urandom_range(0, 1) == 0) ? exp_pc + 64'd4
                                               : ({$urandom, $urandom} & ~64'h3);
            fetch($urandom_range(0, 3), $urandom);
            retire($urandom_range(0, 3), npc, 1'($urandom_range(0, 1)));
        end

        // 4: misaligned NextPC faults; fault state is sticky whatever the inputs do.
        fetch(0, 32'h0000_0013);
        retire(0, 64'h42, 1'b0);
        for (int i = 0; i < 6; i++) begin
            IMemAck    = 1'($urandom_range(0, 1));
            InstrReady = 1'($urandom_range(0, 1));
            NextPC     = {$urandom, $urandom};
            step();
            check("sticky.fault", PCFault,    1'b1);
            check("sticky.req",   IMemReq,    1'b0);
            check("sticky.valid", InstrValid, 1'b0);
            check("sticky.pc",    CurrentPC,  exp_pc);
        end
        IMemAck    = 1'b0;
        InstrReady = 1'b0;

        // 5: reset while requesting with an ack in the same cycle drops the ack.
        do_reset();
        fetch(0, 32'hAAAA_5555);
        retire(0, 64'h100, 1'b0);
        Reset    = 1'b1;
        IMemAck  = 1'b1;
        IMemData = 32'hDEAD_DEAD;
        step();
        Reset   = 1'b0;
        IMemAck = 1'b0;
        check("midrst.pc",    CurrentPC,   RESET_PC);
        check("midrst.valid", InstrValid,  1'b0);
        check("midrst.req",   IMemReq,     1'b0);
        check("midrst.instr", Instruction, '0);
        check("midrst.fault", PCFault,     1'b0);
        exp_pc    = RESET_PC;
        exp_instr = '0;
        step();
        check_requesting("midrst.req_again");
        fetch(2, 32'h5A5A_A5A5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
